// File: rtl/lsu_byte_sequencer.sv
// lsu_byte_sequencer
//   Splits one RV32 load/store (byte, half or word) into sequential
//   single-byte accesses to a 2**ADDR_W x 8 data memory, little-endian,
//   and returns a sign- or zero-extended load result. Misaligned,
//   out-of-range and illegal-funct3 requests are answered with resp_err
//   without any memory strobe.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | req_ready=1; latch request, classify it
//   ACCESS | one memory byte per cycle, lane cnt
//   DONE   | one-cycle resp_valid pulse with registered result
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   req_valid/req_ready      request handshake (accepted only in IDLE)
//   req_we, req_funct3       store flag and RV32 width/sign encoding
//   req_addr, req_wdata      byte address, store data
//   resp_valid/rdata/err     completion pulse, load data, reject flag
//   mem_read_rq/write_rq     memory strobes (never both high)
//   mem_addr, mem_wdata      memory address / write byte
//   mem_rdata                memory read byte, same-cycle combinational
module lsu_byte_sequencer #(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_read_rq,
  output logic              mem_write_rq,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

  state_t            state, state_nxt;
  logic              we_q;
  logic [2:0]        f3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [1:0]        last_q;
  logic [1:0]        cnt;
  logic [31:0]       asm_q;

  logic              illegal, misaligned, out_of_range, req_err;
  logic [1:0]        req_last;
  logic              access_last;
  logic [31:0]       asm_nxt;
  logic [31:0]       load_ext;

  // Request classification, evaluated on the live request in IDLE.
  always_comb begin
    if (req_we)
      illegal = req_funct3[2] | (req_funct3[1:0] == 2'b11);
    else
      illegal = (req_funct3 == 3'b011) | (req_funct3[2:1] == 2'b11);
    misaligned   = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                   ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    out_of_range = |req_addr[31:ADDR_W];
    req_err      = illegal | misaligned | out_of_range;
    case (req_funct3[1:0])
      2'b00:   req_last = 2'd0;
      2'b01:   req_last = 2'd1;
      default: req_last = 2'd3;
    endcase
  end

  assign access_last = (state == S_ACCESS) && (cnt == last_q);

  // Assembly word including the byte being read this cycle, so the final
  // result can be registered on the same edge that captures the last byte.
  always_comb begin
    asm_nxt = asm_q;
    case (cnt)
      2'd0:    asm_nxt[7:0]   = mem_rdata;
      2'd1:    asm_nxt[15:8]  = mem_rdata;
      2'd2:    asm_nxt[23:16] = mem_rdata;
      default: asm_nxt[31:24] = mem_rdata;
    endcase
    case (f3_q)
      3'b000:  load_ext = {{24{asm_nxt[7]}}, asm_nxt[7:0]};
      3'b001:  load_ext = {{16{asm_nxt[15]}}, asm_nxt[15:0]};
      3'b100:  load_ext = {24'h0, asm_nxt[7:0]};
      3'b101:  load_ext = {16'h0, asm_nxt[15:0]};
      default: load_ext = asm_nxt;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (req_valid) state_nxt = req_err ? S_DONE : S_ACCESS;
      S_ACCESS: if (access_last) state_nxt = S_DONE;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready    = (state == S_IDLE);
    resp_valid   = (state == S_DONE);
    mem_read_rq  = 1'b0;
    mem_write_rq = 1'b0;
    mem_addr     = '0;
    mem_wdata    = 8'h00;
    if (state == S_ACCESS) begin
      mem_addr = addr_q + ADDR_W'(cnt);
      if (we_q) begin
        mem_write_rq = 1'b1;
        case (cnt)
          2'd0:    mem_wdata = wdata_q[7:0];
          2'd1:    mem_wdata = wdata_q[15:8];
          2'd2:    mem_wdata = wdata_q[23:16];
          default: mem_wdata = wdata_q[31:24];
        endcase
      end else begin
        mem_read_rq = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      we_q       <= 1'b0;
      f3_q       <= 3'b000;
      addr_q     <= '0;
      wdata_q    <= 32'h0;
      last_q     <= 2'd0;
      cnt        <= 2'd0;
      asm_q      <= 32'h0;
      resp_rdata <= 32'h0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            we_q    <= req_we;
            f3_q    <= req_funct3;
            addr_q  <= req_addr[ADDR_W-1:0];
            wdata_q <= req_wdata;
            last_q  <= req_last;
            cnt     <= 2'd0;
            asm_q   <= 32'h0;
            if (req_err) begin
              resp_rdata <= 32'h0;
              resp_err   <= 1'b1;
            end
          end
        end
        S_ACCESS: begin
          if (!we_q) asm_q <= asm_nxt;
          if (access_last) begin
            resp_rdata <= we_q ? 32'h0 : load_ext;
            resp_err   <= 1'b0;
          end else begin
            cnt <= cnt + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/lsu_byte_sequencer.md
# lsu_byte_sequencer

Load/store sequencer between the RV32IM execute stage and the byte-wide data memory (64 x 8, 6-bit address, separate read/write request strobes). It accepts one LB/LH/LW/LBU/LHU/SB/SH/SW request at a time and splits it into 1, 2 or 4 sequential single-byte memory accesses, little-endian. Loads return a sign- or zero-extended 32-bit result. Misaligned, out-of-range and illegal requests are rejected without touching memory.

## Interface
- ADDR_W, 6, data memory address width; memory holds 2**ADDR_W bytes.

- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  sequencer can accept; high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32 funct3. Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Stores: 000 SB, 001 SH, 010 SW.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; low bytes used for SB/SH.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  load result; 0 for stores and errors.
- resp_err  out  1  request rejected; qualified by resp_valid.
- mem_read_rq  out  1  drives memory read_rq.
- mem_write_rq  out  1  drives memory write_rq.
- mem_addr  out  ADDR_W  drives memory rw_address.
- mem_wdata  out  8  drives memory write_data.
- mem_rdata  in  8  memory read_data; combinational, valid in the same cycle as mem_read_rq.

## Operation
- States: IDLE, ACCESS, DONE.
- **IDLE**
  - req_ready=1.
  - On req_valid: latch we, funct3, addr, wdata. Set byte count n = 1/2/4 from funct3[1:0]. Clear cnt and the data assembly register.
  - Compute err as the OR of:
    - illegal funct3: loads 011/110/111; stores anything except 000/001/010.
    - misaligned: halfword with addr[0]≠0, or word with addr[1:0]≠0.
    - out of range: addr[31:ADDR_W]≠0.
  - err → DONE. Otherwise → ACCESS.
- **ACCESS** (one byte per cycle)
  - mem_addr = addr[ADDR_W-1:0] + cnt. Alignment guarantees no address wrap.
  - Load: mem_read_rq=1. On the clock edge, capture mem_rdata into assembly byte lane cnt.
  - Store: mem_write_rq=1, mem_wdata = req_wdata byte lane cnt. The memory commits it at the clock edge.
  - If cnt == n-1 → DONE, else cnt += 1.
- **DONE**
  - resp_valid=1 for exactly one cycle; then → IDLE.
  - resp_rdata:
    - LB/LH: sign-extend from bit 7/15.
    - LBU/LHU: zero-extend.
    - LW: raw assembled word.
    - Store or err: 0.
  - resp_err = latched err.
- Outside ACCESS: mem_read_rq = mem_write_rq = 0, mem_addr = 0, mem_wdata = 0. The two strobes are never high together.
- resp_rdata and resp_err are registered. They are updated on entry to DONE and hold until the next response.
- req_valid while req_ready=0 is ignored. The requester must hold the request until accepted.

## Timing
- Reset: state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, all mem_* outputs 0, cnt=0.
- Request accepted at edge T (IDLE, req_valid=1):
  - ACCESS occupies cycles T+1 … T+n.
  - resp_valid is high in cycle T+n+1.
  - req_ready returns in cycle T+n+2.
  - Throughput: one request per n+2 cycles.
- Errored request: resp_valid in cycle T+1 with resp_err=1; no memory strobes.
- Reset mid-ACCESS: the sequence aborts at that edge and no response is produced. Store bytes already committed stay written; no rollback.
- Reset during DONE: the pulse is cut; outputs take their reset values.

## Test plan
- SW 0x804012FF to addr 8 → mem_write_rq for 4 cycles: addr 8/9/10/11, wdata FF/12/40/80. Then resp_valid, resp_err=0, resp_rdata=0. A following LW from addr 8 → resp_rdata=0x804012FF at T+5.
- On that data:
  - LB addr 11 → 0xFFFFFF80; LBU addr 11 → 0x00000080.
  - LH addr 10 → 0xFFFF8040; LHU addr 10 → 0x00008040.
  - LB addr 9 → 0x00000012.
  - Check latency T+2 for bytes and T+3 for halfwords.
- Errors, each → resp_valid at T+1 with resp_err=1, resp_rdata=0, no mem strobes ever asserted:
  - LW addr 6, SH addr 3 (misaligned).
  - LW addr 64 (out of range).
  - load funct3=011 (illegal).
- Back-to-back: req_valid held high with SB 0xA5 at addr 0, then LBU addr 0 → second accept exactly at the cycle req_ready returns; result 0x000000A5. Also check req_ready=0 during ACCESS/DONE and that the held request is not double-accepted.
- Reset mid-SW at addr 20 with 0x11223344, asserted after 2 write cycles:
  - No resp_valid; req_ready=1 the cycle after reset.
  - LW addr 20 → 0x00003344.
- Strobe exclusivity checker over all scenarios: mem_read_rq & mem_write_rq never 1; mem_* outputs are 0 outside ACCESS.
